// File: rtl/si53xx_pkg.sv
// Shared definitions for the Si53xx SPI register-interface emulation:
// command encodings, the page-register address and the responder FSM states.
package si53xx_pkg;

    localparam int BYTE_W = 8;

    localparam logic [7:0] CMD_SETADDR   = 8'h00;
    localparam logic [7:0] CMD_WR        = 8'h40;
    localparam logic [7:0] CMD_WRINC     = 8'h60;
    localparam logic [7:0] CMD_RD        = 8'h80;
    localparam logic [7:0] CMD_RDINC     = 8'hA0;

    // Writing this address also updates the page register; reading it returns the page.
    localparam logic [7:0] PAGE_REG_ADDR = 8'h01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        DATA   = 2'd2,
        IGNORE = 2'd3
    } state_e;

    // True for the two commands that return data on sdo.
    function automatic logic is_read_cmd(input logic [7:0] c);
        return (c == CMD_RD) || (c == CMD_RDINC);
    endfunction

    // True for every command byte the responder understands.
    function automatic logic is_legal_cmd(input logic [7:0] c);
        return (c == CMD_SETADDR) || (c == CMD_WR) || (c == CMD_WRINC) ||
               (c == CMD_RD) || (c == CMD_RDINC);
    endfunction

endpackage

// File: rtl/si53xx_regfile.sv
// Paged byte register file: synchronous write, asynchronous read, no reset.
// Contents are undefined until written, matching the real device model.
module si53xx_regfile
    import si53xx_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem_q [2**ADDR_W];

    // Single write port, one byte per clk when we is high.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/si53xx_spi_responder.sv
// SPI mode-0 slave emulating the Si53xx serial register interface.
// All SPI inputs are oversampled by clk; edges are found on the synchronized
// copies. wr_strobe is a valid-only pulse (no ready): wr_page/wr_addr/wr_data
// are meaningful only in the single clk where wr_strobe is high, and the
// register file already holds wr_data in that clk.
module si53xx_spi_responder
    import si53xx_pkg::*;
#(
    parameter int PAGE_BITS   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nCS,
    input  logic       sclk,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_page,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cmd_err,
    output logic       busy
);

    localparam int RF_AW = PAGE_BITS + 8;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic                   ncs_prev_q, ncs_prev_d;
    logic                   sclk_prev_q, sclk_prev_d;

    logic ncs_s, sclk_s, sdi_s;
    logic ncs_fall, ncs_rise, sclk_rise, sclk_fall;

    // Shift each raw input one stage deeper per clk; remember last synchronized level.
    always_comb begin
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], nCS};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
        ncs_prev_d  = ncs_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    end

    // Synchronizer flops; nCS idles deselected so reset never fakes a frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ncs_sync_q  <= '1;
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            ncs_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            ncs_sync_q  <= ncs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            ncs_prev_q  <= ncs_prev_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  sdo_sr_q, sdo_sr_d;
    logic        sdo_q, sdo_d;
    logic        sdo_oe_q, sdo_oe_d;
    logic        busy_q, busy_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [7:0]  wr_page_q, wr_page_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        cmd_err_q, cmd_err_d;

    logic [7:0]       byte_in;
    logic             byte_done;
    logic [7:0]       rd_addr;
    logic [7:0]       rd_byte;
    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [RF_AW-1:0] rf_raddr;
    logic [7:0]       rf_rdata;

    // Read-side address: an RDINC data byte prefetches the following location
    // so the reload at byte end already sees the incremented address.
    always_comb begin
        rd_addr = addr_q;
        if (state_q == DATA && cmd_q == CMD_RDINC) begin
            rd_addr = addr_q + 8'd1;
        end
        rf_raddr = {page_q[PAGE_BITS-1:0], rd_addr};
        rf_waddr = {page_q[PAGE_BITS-1:0], addr_q};
        rd_byte  = (rd_addr == PAGE_REG_ADDR) ? page_q : rf_rdata;
    end

    si53xx_regfile #(
        .ADDR_W (RF_AW)
    ) u_regfile (
        .clk   (clk),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (byte_in),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    // Next-state logic: frame start, bit shifting, byte decode, then frame abort.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        page_d      = page_q;
        addr_d      = addr_q;
        sdo_sr_d    = sdo_sr_q;
        sdo_d       = sdo_q;
        sdo_oe_d    = ~ncs_s;
        busy_d      = ~ncs_s;
        wr_strobe_d = 1'b0;
        wr_page_d   = wr_page_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cmd_err_d   = 1'b0;
        rf_we       = 1'b0;

        byte_in   = {shift_q[6:0], sdi_s};
        byte_done = sclk_rise && (bit_cnt_q == 3'd7);

        if (ncs_fall) begin
            state_d   = CMD;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
            sdo_d     = 1'b0;
        end else if (state_q != IDLE) begin
            if (sclk_rise) begin
                shift_d   = byte_in;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end

            // Mode 0: present the next read bit on each falling edge.
            if (sclk_fall && state_q == DATA && is_read_cmd(cmd_q)) begin
                sdo_d    = sdo_sr_q[7];
                sdo_sr_d = {sdo_sr_q[6:0], 1'b0};
            end

            if (byte_done) begin
                case (state_q)
                    CMD: begin
                        if (is_legal_cmd(byte_in)) begin
                            cmd_d   = byte_in;
                            state_d = DATA;
                            if (is_read_cmd(byte_in)) begin
                                sdo_sr_d = rd_byte;
                            end
                        end else begin
                            cmd_err_d = 1'b1;
                            state_d   = IGNORE;
                        end
                    end
                    DATA: begin
                        case (cmd_q)
                            CMD_SETADDR: begin
                                addr_d  = byte_in;
                                state_d = IGNORE;
                            end
                            CMD_WR, CMD_WRINC: begin
                                rf_we       = 1'b1;
                                wr_strobe_d = 1'b1;
                                // Report the page that addressed this write.
                                wr_page_d   = page_q;
                                wr_addr_d   = addr_q;
                                wr_data_d   = byte_in;
                                if (addr_q == PAGE_REG_ADDR) begin
                                    page_d = byte_in;
                                end
                                if (cmd_q == CMD_WRINC) begin
                                    addr_d = addr_q + 8'd1;
                                end else begin
                                    state_d = IGNORE;
                                end
                            end
                            CMD_RD: begin
                                state_d = IGNORE;
                            end
                            CMD_RDINC: begin
                                addr_d   = addr_q + 8'd1;
                                sdo_sr_d = rd_byte;
                            end
                            default: begin
                                state_d = IGNORE;
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
        end

        // Deselect wins after any byte completing in the same clk.
        if (ncs_rise) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            sdo_d     = 1'b0;
        end

        // sdo only carries data inside a read data byte.
        if (!(state_d == DATA && is_read_cmd(cmd_d))) begin
            sdo_d = 1'b0;
        end
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= 8'h00;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            page_q      <= 8'h00;
            addr_q      <= 8'h00;
            sdo_sr_q    <= 8'h00;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_page_q   <= 8'h00;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            page_q      <= page_d;
            addr_q      <= addr_d;
            sdo_sr_q    <= sdo_sr_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_page_q   <= wr_page_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign sdo       = sdo_q;
    assign sdo_oe    = sdo_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_page   = wr_page_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: doc/si53xx_spi_responder.md
Name: si53xx_spi_responder

Overview:
- Synthesizable SPI slave that emulates the Si53xx (Si5396A) serial register interface.
- It is the far end of si53xx_spi_interface and is used as the bench/loopback target for that master, so master sequences can be checked without the clock chip present.
- Decodes the Si53xx command set (set-address, write, read, and the auto-increment variants) against a paged byte register file.
- Every completed register write is reported on a strobe port so the bench can check it.

Parameters:
- PAGE_BITS, 2, number of implemented page bits; the register file holds 2^PAGE_BITS x 256 bytes, and page-register bits above PAGE_BITS are ignored for addressing.
- SYNC_STAGES, 2, synchronizer depth applied to nCS, sclk and sdi.

Ports:
- clk  in  1  system clock; sclk high and low phases are each >= 4 clk periods.
- reset  in  1  asynchronous, active-high reset.
- nCS  in  1  chip select from master, active-low.
- sclk  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), MSB first.
- sdi  in  1  serial data from master (connects to the master's sdo).
- sdo  out  1  serial data to master (connects to the master's sdi).
- sdo_oe  out  1  high while the frame is selected.
- wr_strobe  out  1  one-clk pulse per committed register write.
- wr_page  out  8  page register value at commit.
- wr_addr  out  8  address at commit.
- wr_data  out  8  data written.
- cmd_err  out  1  one-clk pulse on an unsupported command byte.
- busy  out  1  high while the synchronized nCS is low.

Behaviour:
- Reset (async): all outputs 0; page=0, addr=0, FSM=IDLE, bit counter=0. Register-file contents are not reset (undefined until written).
- Inputs pass through SYNC_STAGES flops. Edge detection is done on synchronized sclk.
  - Rising edge: shift sdi into shift register, increment 3-bit bit counter.
  - Falling edge: shift sdo.
- Frame starts on synchronized nCS falling edge. Bit counter and shift register are cleared; FSM goes to CMD.
- CMD state: on the 8th rising edge, latch the command byte.
  - 0x00 SETADDR, 0x40 WR, 0x60 WRINC, 0x80 RD, 0xA0 RDINC → DATA.
  - Any other value → cmd_err pulse, FSM goes to IGNORE.
- RD/RDINC preload: in the same clk as command latch, load the sdo shift register from rd_byte.
  - rd_byte = page register when addr==0x01, else regfile[{page[PAGE_BITS-1:0],addr}].
  - The following sclk falling edge drives bit7; each later falling edge drives the next bit.
- DATA state, action on the 8th rising edge of each data byte:
  - SETADDR: addr <= byte.
  - WR/WRINC: write regfile (and page <= byte if addr==0x01); pulse wr_strobe with wr_page/wr_addr/wr_data valid in that same cycle.
  - WRINC/RDINC: addr <= addr+1, wrapping 0xFF→0x00 with page unchanged.
  - RDINC: reload the sdo shift register from the new address for the next byte.
- Extra data bytes after a non-increment command are ignored: FSM goes to IGNORE, sdo=0.
- IGNORE state: consume clocks, no side effects.
- nCS rising edge, any state: FSM → IDLE; a partial byte is discarded and never written; sdo=0.
- sdo is 0 when not in a read DATA byte.
- Simultaneous events:
  - nCS rise and the 8th sclk rise in the same synchronized clk: the byte completes first, then the abort.
  - Async reset mid-frame: immediate return to reset state.
- Write commit latency from the 8th synchronized sclk rise: 1 clk.

Decomposition:
- Shared package si53xx_pkg holds:
  - Command constants CMD_SETADDR=8'h00, CMD_WR=8'h40, CMD_WRINC=8'h60, CMD_RD=8'h80, CMD_RDINC=8'hA0.
  - PAGE_REG_ADDR=8'h01.
  - FSM state enum {IDLE, CMD, DATA, IGNORE}.
- Sub-module si53xx_regfile: synchronous write, asynchronous read, depth 2^(PAGE_BITS+8), no reset.

Test Plan:
- Frame 0x00,0x23, then frame 0x40,0xA5, then frame 0x80,0x00 → wr_strobe once with page=0/addr=0x23/data=0xA5; sdo returns 0xA5 MSB-first on the read byte.
- Write 0x02 to addr 0x01, then write 0x5A to addr 0x10, then set page 0 and read 0x10 → page-0 data unchanged; after switching back to page 2, reading 0x10 returns 0x5A.
- SETADDR 0xFE, then WRINC burst 0x11,0x22,0x33 in one nCS frame → wr_addr sequence 0xFE,0xFF,0x00; RDINC from 0xFE returns 0x11,0x22,0x33.
- Command 0xC0 → cmd_err pulses once, no wr_strobe, sdo stays 0 for the frame.
- WR frame with nCS deasserted after 5 data bits → no wr_strobe; target location keeps its previous value.
- Drive with si53xx_spi_interface (read=1, rw_addr=0xAA) after preloading 0xAA with 0x3C via frames → master read_data equals 0x3C.
